// File: rtl/wave_capture_pkg.sv
// Shared capture-state encoding and default geometry for the trigger, capture and readout blocks.
package wave_capture_pkg;
   localparam int DEF_DATA_W     = 14;
   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_RECORD_LEN = 1000;
   localparam int DEF_PRETRIG    = 100;
   localparam int DEF_WNUM_W     = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } capture_state_t;
endpackage

// File: rtl/wave_ram.sv
// Simple dual-port sample RAM: one write port, registered read port (1-cycle latency), no reset.
module wave_ram #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/wave_capture_buffer.sv
// Pre-trigger circular capture buffer: records samples continuously, freezes a window around a
// trigger, then serves the frozen record by index with a 2-cycle read pipeline.
module wave_capture_buffer
   import wave_capture_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int RECORD_LEN = DEF_RECORD_LEN,
   parameter int PRETRIG    = DEF_PRETRIG,
   parameter int WNUM_W     = DEF_WNUM_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              trigger_in,
   input  logic              arm,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   output logic              busy,
   output logic              wave_done,
   output logic [WNUM_W-1:0] wave_number
);
   localparam int POST_LEN = RECORD_LEN - PRETRIG;
   localparam int CNT_W    = $clog2(RECORD_LEN + 1);
   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRETRIG - 1);
   localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_LEN - 1);

   capture_state_t    state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] start_ptr;
   logic [CNT_W-1:0]  pre_cnt;
   logic [CNT_W-1:0]  post_cnt;
   logic              wr_en;
   logic              enter_done;
   logic              rd_acc;
   logic              addr_oor;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_q;
   logic              rd_pipe;
   logic              err_pipe;

   assign rd_ready    = (state == DONE);
   assign busy        = (state == FILL) || (state == ARMED) || (state == POST);
   assign rd_acc      = rd_req & rd_ready;
   assign addr_oor    = (int'(rd_addr) >= RECORD_LEN);
   assign ram_rd_addr = start_ptr + rd_addr;

   always_comb begin
      state_nxt  = state;
      wr_en      = 1'b0;
      enter_done = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (arm) state_nxt = FILL;
         end
         FILL: begin
            if (sample_valid) begin
               wr_en = 1'b1;
               if (pre_cnt == PRE_LAST) state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (sample_valid) begin
               wr_en = 1'b1;
               if (trigger_in) begin
                  if (POST_LEN == 1) begin
                     state_nxt  = DONE;
                     enter_done = 1'b1;
                  end else begin
                     state_nxt = POST;
                  end
               end
            end
         end
         POST: begin
            if (sample_valid) begin
               wr_en = 1'b1;
               if (post_cnt == POST_LAST) begin
                  state_nxt  = DONE;
                  enter_done = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         start_ptr   <= '0;
         pre_cnt     <= '0;
         post_cnt    <= '0;
         wave_done   <= 1'b0;
         wave_number <= '0;
         rd_pipe     <= 1'b0;
         err_pipe    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_err      <= 1'b0;
         rd_data     <= '0;
      end else begin
         state     <= state_nxt;
         wave_done <= enter_done;
         if (enter_done) wave_number <= wave_number + WNUM_W'(1);
         if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);

         if ((state == IDLE || state == DONE) && arm) pre_cnt <= '0;
         else if (state == FILL && sample_valid) pre_cnt <= pre_cnt + CNT_W'(1);

         // The trigger sample lands at wr_ptr, so the record starts PRETRIG slots behind it.
         if (state == ARMED && sample_valid && trigger_in) begin
            start_ptr <= wr_ptr - ADDR_W'(PRETRIG);
            post_cnt  <= CNT_W'(1);
         end else if (state == POST && sample_valid) begin
            post_cnt <= post_cnt + CNT_W'(1);
         end

         rd_pipe  <= rd_acc;
         err_pipe <= rd_acc & addr_oor;
         rd_valid <= rd_pipe;
         rd_err   <= err_pipe;
         rd_data  <= (rd_pipe && !err_pipe) ? ram_q : '0;
      end
   end

   wave_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (sample_in),
      .rd_en   (rd_acc),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_q)
   );
endmodule
